inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/cpu_defs.sv | 19 +
 rtl/inst_fetch_if.sv | 21 ++
 rtl/pc_reg.sv | 59 +++++
 rtl/inst_fetch.sv | 79 +++++++
 tb/tb_inst_fetch.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: word constants, ROM geometry and the fetch FSM encoding.
package cpu_defs;
  localparam int          DATA_W     = 32;
  localparam int          ROM_AW     = 6;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [31:0] PC_RESET   = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Instruction addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction
endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction ROM port plus the IF/ID payload handed to decode.
interface inst_fetch_if;
  import cpu_defs::*;

  logic              rom_ce;
  logic [ROM_AW-1:0] rom_addr;
  logic [DATA_W-1:0] rom_inst;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_inst;
  logic              id_valid;

  modport master (
    output rom_ce, rom_addr, id_pc, id_inst, id_valid,
    input  rom_inst
  );

  modport slave (
    input  rom_ce, rom_addr, id_pc, id_inst, id_valid,
    output rom_inst
  );
endinterface

// File: rtl/pc_reg.sv
// Program counter with a pending-branch latch for branches that resolve while the front end is stalled.
module pc_reg
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] pc
);

  logic [DATA_W-1:0] pc_next;
  logic [DATA_W-1:0] pend_pc, pend_pc_next;
  logic              pend_vld, pend_vld_next;

  // Priority: flush > stall > new branch > pending branch > sequential.
  always_comb begin
    pc_next       = pc;
    pend_pc_next  = pend_pc;
    pend_vld_next = pend_vld;
    if (en) begin
      if (flush) begin
        pc_next       = align_word(flush_pc);
        pend_pc_next  = ZERO_WORD;
        pend_vld_next = 1'b0;
      end else if (stall) begin
        if (branch_flag) begin
          pend_pc_next  = align_word(branch_target);
          pend_vld_next = 1'b1;
        end
      end else if (branch_flag) begin
        pc_next       = align_word(branch_target);
        pend_vld_next = 1'b0;
      end else if (pend_vld) begin
        pc_next       = pend_pc;
        pend_vld_next = 1'b0;
      end else begin
        pc_next = pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= PC_RESET;
      pend_pc  <= ZERO_WORD;
      pend_vld <= 1'b0;
    end else begin
      pc       <= pc_next;
      pend_pc  <= pend_pc_next;
      pend_vld <= pend_vld_next;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: fetch FSM, IF/ID pipeline register and delivered-instruction counter.
module inst_fetch
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [DATA_W-1:0] branch_target,
  inst_fetch_if.master      bus,
  output logic [DATA_W-1:0] fetch_cnt
);

  fetch_state_e      state, state_next;
  logic              active;
  logic              fetch_fire;
  logic [DATA_W-1:0] pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    active     = 1'b0;
    unique case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        active = 1'b1;
        if (flush)      state_next = FETCH;
        else if (stall) state_next = HOLD;
      end
      HOLD: begin
        active = 1'b1;
        if (flush || !stall) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  assign fetch_fire   = active & ~flush & ~stall;
  assign bus.rom_ce   = active;
  assign bus.rom_addr = pc[ROM_AW+1:2];

  pc_reg u_pc_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (active),
    .stall        (stall),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .pc           (pc)
  );

  // IF/ID boundary: ROM word lands in decode one edge after its address is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.id_pc    <= ZERO_WORD;
      bus.id_inst  <= ZERO_WORD;
      bus.id_valid <= 1'b0;
      fetch_cnt    <= ZERO_WORD;
    end else if (active && flush) begin
      bus.id_pc    <= ZERO_WORD;
      bus.id_inst  <= ZERO_WORD;
      bus.id_valid <= 1'b0;
    end else if (fetch_fire) begin
      bus.id_pc    <= pc;
      bus.id_inst  <= bus.rom_inst;
      bus.id_valid <= 1'b1;
      fetch_cnt    <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: per-cycle vector table plus hand sequences for reset corners.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, branch_flag;
  logic [31:0] flush_pc, branch_target;
  logic [31:0] fetch_cnt;
  logic [31:0] rom [64];

  int errors = 0;
  int checks = 0;

  inst_fetch_if bus ();

  inst_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .bus          (bus),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  always_comb bus.rom_inst = bus.rom_ce ? rom[bus.rom_addr] : 32'h0;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;
    logic [5:0]  e_addr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic f, input logic [31:0] fpc,
                     input logic b, input logic [31:0] t,
                     input logic [31:0] epc, input logic [31:0] einst,
                     input logic ev, input logic [5:0] ea, input logic [31:0] ec);
    vec_t v;
    v.stall = s; v.flush = f; v.flush_pc = fpc; v.br = b; v.tgt = t;
    v.e_pc = epc; v.e_inst = einst; v.e_valid = ev; v.e_addr = ea; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] epc, input logic [31:0] einst,
                         input logic ev, input logic ece, input logic [5:0] ea,
                         input logic [31:0] ec);
    chk({tag, ".id_pc"},     bus.id_pc,            epc);
    chk({tag, ".id_inst"},   bus.id_inst,          einst);
    chk({tag, ".id_valid"},  {31'b0, bus.id_valid}, {31'b0, ev});
    chk({tag, ".rom_ce"},    {31'b0, bus.rom_ce},   {31'b0, ece});
    chk({tag, ".rom_addr"},  {26'b0, bus.rom_addr}, {26'b0, ea});
    chk({tag, ".fetch_cnt"}, fetch_cnt,            ec);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; flush = 1'b0; branch_flag = 1'b0;
    flush_pc = 32'h0; branch_target = 32'h0;
  endtask

  initial begin
    rom[0] = 32'h3401_1100;
    rom[1] = 32'h3402_0020;
    rom[2] = 32'h3403_ff00;
    rom[3] = 32'h3404_ffff;
    for (int i = 4; i < 64; i++) rom[i] = 32'h1000_0000 + i;

    // stall flush fpc br tgt | id_pc id_inst valid rom_addr cnt
    add(0,0,0,0,0,            32'h0,   32'h0,         0, 0,  0);  // IDLE -> FETCH
    add(0,0,0,0,0,            32'h0,   32'h3401_1100, 1, 1,  1);
    add(0,0,0,0,0,            32'h4,   32'h3402_0020, 1, 2,  2);
    add(0,0,0,0,0,            32'h8,   32'h3403_ff00, 1, 3,  3);
    add(0,0,0,0,0,            32'hC,   32'h3404_ffff, 1, 4,  4);
    add(0,0,0,1,32'h40,       32'h10,  32'h1000_0004, 1, 16, 5);  // branch, delay slot kept
    add(0,0,0,0,0,            32'h40,  32'h1000_0010, 1, 17, 6);
    add(0,0,0,1,32'h4,        32'h44,  32'h1000_0011, 1, 1,  7);
    add(0,0,0,0,0,            32'h4,   32'h3402_0020, 1, 2,  8);  // pc now 8
    add(1,0,0,0,0,            32'h4,   32'h3402_0020, 1, 2,  8);  // stall x3
    add(1,0,0,0,0,            32'h4,   32'h3402_0020, 1, 2,  8);
    add(1,0,0,0,0,            32'h4,   32'h3402_0020, 1, 2,  8);
    add(0,0,0,0,0,            32'h8,   32'h3403_ff00, 1, 3,  9);
    add(1,0,0,1,32'h30,       32'h8,   32'h3403_ff00, 1, 3,  9);  // branch during stall
    add(1,0,0,1,32'h23,       32'h8,   32'h3403_ff00, 1, 3,  9);  // overwrite, unaligned
    add(0,0,0,0,0,            32'hC,   32'h3404_ffff, 1, 8,  10); // pending applied
    add(0,0,0,0,0,            32'h20,  32'h1000_0008, 1, 9,  11);
    add(1,0,0,1,32'h60,       32'h20,  32'h1000_0008, 1, 9,  11); // pending 0x60
    add(1,1,32'h81,1,32'h60,  32'h0,   32'h0,         0, 32, 11); // flush wins
    add(0,0,0,0,0,            32'h80,  32'h1000_0020, 1, 33, 12);
    add(0,0,0,0,0,            32'h84,  32'h1000_0021, 1, 34, 13); // pending was dropped
    add(0,0,0,1,32'hF8,       32'h88,  32'h1000_0022, 1, 62, 14);
    add(0,0,0,0,0,            32'hF8,  32'h1000_003E, 1, 63, 15);
    add(0,0,0,0,0,            32'hFC,  32'h1000_003F, 1, 0,  16); // rom_addr 63 -> 0
    add(0,0,0,0,0,            32'h100, 32'h3401_1100, 1, 1,  17);
    add(0,0,0,1,32'hFFFF_FFFC,32'h104, 32'h3402_0020, 1, 63, 18);
    add(0,0,0,0,0,            32'hFFFF_FFFC, 32'h1000_003F, 1, 0, 19);
    add(0,0,0,0,0,            32'h0,   32'h3401_1100, 1, 1,  20); // 32-bit wrap

    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk_out("reset_early", 32'h0, 32'h0, 0, 0, 6'd0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset_hold", 32'h0, 32'h0, 0, 0, 6'd0, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].stall; flush = vecs[i].flush; flush_pc = vecs[i].flush_pc;
      branch_flag = vecs[i].br; branch_target = vecs[i].tgt;
      @(posedge clk);
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_valid,
              1'b1, vecs[i].e_addr, vecs[i].e_cnt);
    end

    // Reset asserted mid-stall with a branch pending.
    idle_inputs();
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h40;
    @(posedge clk);
    #1;
    chk_out("pre_rst_stall", 32'h0, 32'h3401_1100, 1, 1, 6'd1, 32'd20);
    branch_flag = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 32'h0, 32'h0, 0, 0, 6'd0, 32'h0);
    @(posedge clk);
    #1;
    chk_out("rst_held", 32'h0, 32'h0, 0, 0, 6'd0, 32'h0);
    stall = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_out("post_rst_idle", 32'h0, 32'h0, 0, 1, 6'd0, 32'h0);
    @(posedge clk);
    #1;
    chk_out("post_rst_fetch0", 32'h0, 32'h3401_1100, 1, 1, 6'd1, 32'd1);
    @(posedge clk);
    #1;
    chk_out("post_rst_fetch1", 32'h4, 32'h3402_0020, 1, 1, 6'd2, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
